// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies, FSM states.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath; the controller latches its result at start
// and exposes it only after the configured busy latency.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div0
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic        [31:0] q_u;
    logic        [31:0] r_u;
    logic               ovf;

    assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
    assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};
    assign div0   = (rt_val == 32'd0);
    // The most-negative / -1 quotient does not fit; pin it to the wrapped MIPS result.
    assign ovf    = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

    always_comb begin
        q_s = '0;
        r_s = '0;
        q_u = '0;
        r_u = '0;
        if (ovf) begin
            q_s = $signed(32'h8000_0000);
        end else if (!div0) begin
            q_s = $signed(rs_val) / $signed(rt_val);
            r_s = $signed(rs_val) % $signed(rt_val);
        end
        if (!div0) begin
            q_u = rs_val / rt_val;
            r_u = rs_val % rt_val;
        end
    end

    always_comb begin
        hi_res = '0;
        lo_res = '0;
        case (op)
            MDU_MULT:  begin hi_res = prod_s[63:32]; lo_res = prod_s[31:0]; end
            MDU_MULTU: begin hi_res = prod_u[63:32]; lo_res = prod_u[31:0]; end
            MDU_DIV:   begin hi_res = r_s;           lo_res = q_s;          end
            MDU_DIVU:  begin hi_res = r_u;           lo_res = q_u;          end
            default:   begin hi_res = '0;            lo_res = '0;           end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide controller: sequences multi-cycle ops with a down-counter,
// owns HI/LO, and stalls D-stage HI/LO users while an op is in flight.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        d_md_use,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        hi_nxt_q, hi_nxt_d, lo_nxt_q, lo_nxt_d;
    logic               div0_q, div0_d;

    logic [31:0]        hi_res, lo_res;
    logic               div0;
    logic               is_div;

    mdu_arith u_arith (
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .div0   (div0)
    );

    assign is_div = (op == MDU_DIV) || (op == MDU_DIVU);
    assign start  = req && (op <= MDU_DIVU) && (state_q == S_IDLE);
    assign busy   = (state_q == S_BUSY);
    assign stall  = d_md_use && (start || busy);
    assign hi     = hi_q;
    assign lo     = lo_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_nxt_d = hi_nxt_q;
        lo_nxt_d = lo_nxt_q;
        div0_d   = div0_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    hi_nxt_d = hi_res;
                    lo_nxt_d = lo_res;
                    div0_d   = is_div && div0;
                    cnt_d    = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    state_d  = S_BUSY;
                end else if (req && op == MDU_MTHI) begin
                    hi_d = rs_val;
                end else if (req && op == MDU_MTLO) begin
                    lo_d = rs_val;
                end
            end
            S_BUSY: begin
                // Requests are ignored here; the D-stage stall keeps them from arriving legally.
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    if (!div0_q) begin
                        hi_d = hi_nxt_q;
                        lo_d = lo_nxt_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_nxt_q <= '0;
            lo_nxt_q <= '0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_nxt_q <= hi_nxt_d;
            lo_nxt_q <= lo_nxt_d;
            div0_q   <= div0_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl: table of ops with hand-computed HI/LO and busy length,
// plus sequences for stall, MTLO-while-busy and reset mid-divide.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [2:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_md_use;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .d_md_use (d_md_use),
        .start    (start),
        .busy     (busy),
        .stall    (stall),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int idx, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input int ecyc);
        logic [31:0] phi, plo;
        int n;
        phi = hi;
        plo = lo;
        req = 1'b1; op = o; rs_val = a; rt_val = b;
        #1;
        chk($sformatf("v%0d start", idx), {31'd0, start}, {31'd0, (o <= 3'd3)});
        tick();
        req = 1'b0;
        n = 0;
        while (busy && n < 200) begin
            n++;
            chk($sformatf("v%0d hi held", idx), hi, phi);
            chk($sformatf("v%0d lo held", idx), lo, plo);
            tick();
        end
        chk($sformatf("v%0d busy cycles", idx), n, ecyc);
        chk($sformatf("v%0d hi", idx), hi, ehi);
        chk($sformatf("v%0d lo", idx), lo, elo);
    endtask

    initial begin
        // op, rs, rt, expected hi, expected lo, busy cycles
        tbl[0]  = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
        tbl[1]  = '{3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA, 5};
        tbl[2]  = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        tbl[3]  = '{3'd3, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
        tbl[4]  = '{3'd4, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFD, 0};
        tbl[5]  = '{3'd5, 32'h9ABC_DEF0, 32'h0000_0000, 32'h1234_5678, 32'h9ABC_DEF0, 0};
        tbl[6]  = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 10};
        tbl[7]  = '{3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 10};
        tbl[8]  = '{3'd0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 5};
        tbl[9]  = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10};
        tbl[10] = '{3'd6, 32'hDEAD_BEEF, 32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFD, 0};
        tbl[11] = '{3'd2, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFD, 10};

        reset = 1'b0; req = 1'b0; op = '0; rs_val = '0; rt_val = '0; d_md_use = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        tick();

        // tbl[6] -> tbl[7] is back-to-back: the DIVU issues on the first non-busy cycle.
        for (int i = 0; i < 12; i++)
            run_op(i, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].hi, tbl[i].lo, tbl[i].cyc);

        // Stall with d_md_use held high: start cycle plus 5 busy cycles, low on the 7th.
        d_md_use = 1'b1; req = 1'b1; op = 3'd0; rs_val = 32'd2; rt_val = 32'd3;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk($sformatf("stall use c%0d", i), {31'd0, stall}, {31'd0, (i < 6)});
            tick();
            req = 1'b0;
        end
        chk("stall mult lo", lo, 32'd6);
        d_md_use = 1'b0; req = 1'b1; op = 3'd0; rs_val = 32'd4; rt_val = 32'd5;
        for (int i = 0; i < 7; i++) begin
            #1;
            chk($sformatf("stall nouse c%0d", i), {31'd0, stall}, 32'd0);
            tick();
            req = 1'b0;
        end
        chk("nouse mult lo", lo, 32'd20);

        // MTLO injected while busy must be dropped.
        req = 1'b1; op = 3'd0; rs_val = 32'd5; rt_val = 32'd7;
        tick();
        req = 1'b0;
        tick();
        req = 1'b1; op = 3'd5; rs_val = 32'hDEAD_BEEF;
        #1;
        chk("mtlo busy start", {31'd0, start}, 32'd0);
        tick();
        req = 1'b0;
        chk("mtlo busy lo held", lo, 32'd20);
        for (int n = 0; n < 20 && busy; n++) tick();
        chk("mtlo busy busy", {31'd0, busy}, 32'd0);
        chk("mtlo busy hi", hi, 32'd0);
        chk("mtlo busy lo", lo, 32'd35);

        // Reset held three cycles in the middle of a DIV.
        req = 1'b1; op = 3'd2; rs_val = 32'd100; rt_val = 32'd7;
        tick();
        req = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        chk("rst mid hi", hi, 32'd0);
        chk("rst mid lo", lo, 32'd0);
        chk("rst mid busy", {31'd0, busy}, 32'd0);
        repeat (12) tick();
        chk("rst late hi", hi, 32'd0);
        chk("rst late lo", lo, 32'd0);
        chk("rst late busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
